rdma_ctyun_sdpram_ext: RTL and testbench
========================================

// Module: rdma_ctyun_sdpram_ext
// PURPOSE
//  Simple dual-port RAM, next generation after the plain SDP wrapper: one write port, one read port, same width.
//  Adds the following over the plain wrapper:
//   - Power-on/reset clear of the whole array.
//   - Read latency programmable from 1 to 4.
//   - Read-valid tracking.
//   - Byte-merged NEW_DATA forwarding on same-cycle address collisions, for any RAM type.
//  Used for RDMA context/queue tables that must start zeroed and be read-after-written without software stalls.
// PARAMETERS
//  ADDR_WIDTH    8       address bits; NUM_WORDS = 2**ADDR_WIDTH
//  DATA_WIDTH    32      data bits; byte lanes BE_W = (DATA_WIDTH+7)/8, top lane partial if not multiple of 8
//  READ_LATENCY  2       1..4 cycles from rden sample to dout/dout_valid; other values are illegal (elaboration error)
//  RAM_TYPE      "AUTO"  AUTO, M20K or MLAB; synthesis hint only
//  FWD_EN        1       1: same-cycle collision returns new bytes; 0: returns old data
//  CLEAR_ON_RST  1       1: zero the array after reset; 0: skip the clear, init_done high one cycle after reset release
// PORTS
//  clock      in   1           single clock, rising edge
//  resetn     in   1           synchronous, active-low reset
//  wren       in   1           write enable (ignored while init_done=0)
//  byteena    in   BE_W        per-lane write enable; lane i covers din[8i+7:8i]
//  wraddress  in   ADDR_WIDTH  write address
//  din        in   DATA_WIDTH  write data
//  rden       in   1           read enable (ignored while init_done=0)
//  rdaddress  in   ADDR_WIDTH  read address
//  dout       out  DATA_WIDTH  read data; holds last value when no new read completes
//  dout_valid out  1           1-cycle pulse, READ_LATENCY cycles after an accepted rden
//  init_done  out  1           0 during clear, 1 when ports are usable
// BEHAVIOUR
//  Reset (resetn=0 at an edge):
//   - dout=0, dout_valid=0, init_done=0, clear counter=0.
//   - All read pipeline stages and the forwarding register are flushed.
//   - Array contents are not touched by reset itself.
//  FSM states: CLEAR, READY.
//   - Reset enters CLEAR if CLEAR_ON_RST=1, else READY.
//   - CLEAR: one word per cycle writes all lanes of addr=cnt to 0, then cnt++.
//   - CLEAR -> READY on the cycle after cnt = NUM_WORDS-1 is written.
//   - READY is terminal until the next reset.
//   - Reset asserted mid-clear restarts the clear at address 0.
//  init_done=1 in READY; it rises exactly NUM_WORDS+1 edges after the first edge with resetn=1.
//  Write: at an edge with wren & init_done, lanes with byteena[i]=1 are updated; other lanes keep their value.
//   - byteena=0 with wren=1 is a no-op.
//  Read: an accepted rden samples rdaddress at edge t.
//   - dout shows the array contents as of before the edge-t write (OLD_DATA base).
//   - dout is updated and dout_valid=1 after edge t+READ_LATENCY-1, i.e. visible in cycle t+READ_LATENCY.
//   - Writes at edges < t are always visible.
//  Collision: wren & rden at the same edge, wraddress==rdaddress, FWD_EN=1:
//   - Lanes with byteena=1 return din.
//   - Other lanes return old data.
//   - The merge is done on the registered write info at the output stage; latency is unchanged.
//   - With FWD_EN=0, returns old data unchanged.
//  Back-to-back reads are fully pipelined: 1 read/cycle, no bubbles, in order.
//  Reads issued to any address in the same cycle as a write to a different address are unaffected.
//  dout_valid=0 in cycles with no completing read; dout is held, not zeroed.
// TESTING
//  1 Reset release, ADDR_WIDTH=4, CLEAR_ON_RST=1: init_done=1 after 17 edges; reads of addr 0..15 -> dout=0.
//  2 Write 0xDEADBEEF to addr 5, next cycle read 5, READ_LATENCY=1..4 -> dout_valid and 0xDEADBEEF at exactly
//    cycle t+L each run.
//  3 Addr 9 holds 0x11223344; in the same cycle write 0xAABBCCDD, byteena=4'b0101, and read 9:
//    FWD_EN=1 -> 0x11BB33DD; FWD_EN=0 -> 0x11223344; a following read -> 0x11BB33DD.
//  4 Streaming 16 consecutive reads (addr 0..15): dout_valid high 16 consecutive cycles, data in order,
//    dout held after the last read.
//  5 Reset asserted mid-clear at cnt=7 after writing 0x55 to all words earlier:
//    clear restarts at 0; all words read 0 after init_done; wren/rden during clear have no effect.
//  6 DATA_WIDTH=20 (BE_W=3, partial top lane): byteena=3'b100 writes only bits 19:16.

Source files
------------

// File: rtl/rdma_ctyun_sdpram_ext_if.sv
// rtl/rdma_ctyun_sdpram_ext_if.sv - write/read port bundle for the extended simple dual-port RAM
interface rdma_ctyun_sdpram_ext_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);
   localparam int BE_W = (DATA_WIDTH + 7) / 8;

   logic                  wren;
   logic [BE_W-1:0]       byteena;
   logic [ADDR_WIDTH-1:0] wraddress;
   logic [DATA_WIDTH-1:0] din;
   logic                  rden;
   logic [ADDR_WIDTH-1:0] rdaddress;
   logic [DATA_WIDTH-1:0] dout;
   logic                  dout_valid;
   logic                  init_done;

   modport master (
      output wren, byteena, wraddress, din, rden, rdaddress,
      input  dout, dout_valid, init_done
   );

   modport slave (
      input  wren, byteena, wraddress, din, rden, rdaddress,
      output dout, dout_valid, init_done
   );
endinterface

// File: rtl/rdma_ctyun_sdpram_ext.sv
// rtl/rdma_ctyun_sdpram_ext.sv - SDP RAM with reset clear, 1..4 cycle read latency and byte-merged forwarding
module rdma_ctyun_sdpram_ext #(
   parameter int    ADDR_WIDTH   = 8,
   parameter int    DATA_WIDTH   = 32,
   parameter int    READ_LATENCY = 2,
   parameter string RAM_TYPE     = "AUTO",
   parameter bit    FWD_EN       = 1'b1,
   parameter bit    CLEAR_ON_RST = 1'b1
) (
   input  logic                   clock,
   input  logic                   resetn,
   rdma_ctyun_sdpram_ext_if.slave bus
);
   localparam int NUM_WORDS = 2 ** ADDR_WIDTH;
   localparam int BE_W      = (DATA_WIDTH + 7) / 8;

   if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
      $error("READ_LATENCY must be 1..4");
   end
   if (RAM_TYPE != "AUTO" && RAM_TYPE != "M20K" && RAM_TYPE != "MLAB") begin : g_bad_ram_type
      $error("RAM_TYPE must be AUTO, M20K or MLAB");
   end

   typedef enum logic {CLEAR, READY} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] cnt;
   logic                  init_done_q;
   logic [DATA_WIDTH-1:0] dout_q;
   logic                  dout_valid_q;
   logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

   logic                  wr_ok;
   logic                  rd_ok;
   logic [BE_W-1:0]       fwd_be_now;
   logic                  o_valid;
   logic [DATA_WIDTH-1:0] o_raw;
   logic [DATA_WIDTH-1:0] o_din;
   logic [BE_W-1:0]       o_be;

   function automatic logic [DATA_WIDTH-1:0] merge_lanes(
      input logic [DATA_WIDTH-1:0] old_d,
      input logic [DATA_WIDTH-1:0] new_d,
      input logic [BE_W-1:0]       be
   );
      logic [DATA_WIDTH-1:0] r;
      r = old_d;
      for (int b = 0; b < DATA_WIDTH; b++) begin
         if (be[b / 8]) r[b] = new_d[b];
      end
      return r;
   endfunction

   assign wr_ok = resetn && init_done_q && bus.wren;
   assign rd_ok = resetn && init_done_q && bus.rden;
   // Collision lanes travel with the read; an all-zero mask means "return old data".
   assign fwd_be_now = (FWD_EN && wr_ok && rd_ok && bus.wraddress == bus.rdaddress)
                       ? bus.byteena : '0;

   always_ff @(posedge clock) begin
      if (resetn && state == CLEAR) begin
         mem[cnt] <= '0;
      end else if (wr_ok) begin
         for (int b = 0; b < DATA_WIDTH; b++) begin
            if (bus.byteena[b / 8]) mem[bus.wraddress][b] <= bus.din[b];
         end
      end
   end

   if (READ_LATENCY == 1) begin : g_lat1
      assign o_valid = rd_ok;
      assign o_raw   = mem[bus.rdaddress];
      assign o_din   = bus.din;
      assign o_be    = fwd_be_now;
   end else begin : g_pipe
      localparam int P = READ_LATENCY - 1;
      logic [P-1:0]          pv;
      logic [DATA_WIDTH-1:0] praw [P];
      logic [DATA_WIDTH-1:0] pdin [P];
      logic [BE_W-1:0]       pbe  [P];

      always_ff @(posedge clock) begin
         if (!resetn) begin
            for (int i = 0; i < P; i++) begin
               pv[i]   <= 1'b0;
               praw[i] <= '0;
               pdin[i] <= '0;
               pbe[i]  <= '0;
            end
         end else begin
            pv[0]   <= rd_ok;
            praw[0] <= mem[bus.rdaddress];
            pdin[0] <= bus.din;
            pbe[0]  <= fwd_be_now;
            for (int i = 1; i < P; i++) begin
               pv[i]   <= pv[i-1];
               praw[i] <= praw[i-1];
               pdin[i] <= pdin[i-1];
               pbe[i]  <= pbe[i-1];
            end
         end
      end

      assign o_valid = pv[P-1];
      assign o_raw   = praw[P-1];
      assign o_din   = pdin[P-1];
      assign o_be    = pbe[P-1];
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state        <= CLEAR_ON_RST ? CLEAR : READY;
         cnt          <= '0;
         init_done_q  <= 1'b0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
      end else begin
         case (state)
            CLEAR: begin
               cnt <= cnt + 1'b1;
               if (cnt == ADDR_WIDTH'(NUM_WORDS - 1)) state <= READY;
            end
            READY: init_done_q <= 1'b1;
            default: state <= READY;
         endcase
         dout_valid_q <= o_valid;
         if (o_valid) dout_q <= merge_lanes(o_raw, o_din, o_be);
      end
   end

   assign bus.dout       = dout_q;
   assign bus.dout_valid = dout_valid_q;
   assign bus.init_done  = init_done_q;
endmodule

// File: tb/tb_rdma_ctyun_sdpram_ext.sv
// tb/tb_rdma_ctyun_sdpram_ext.sv - directed bench over latencies 1..4, FWD_EN=0 and a 20-bit instance
module tb_rdma_ctyun_sdpram_ext;
   logic        clock = 1'b0;
   logic        resetn;
   logic        wren;
   logic [3:0]  be;
   logic [3:0]  wa;
   logic [31:0] din;
   logic        rden;
   logic [3:0]  ra;

   logic [4:1][31:0] dout_l;
   logic [4:1]       valid_l;
   logic [4:1]       init_l;

   int n_vec = 0;
   int n_err = 0;

   logic [3:0]  rlist [16];
   logic [31:0] e_fwd [16];
   logic [31:0] e_old [16];

   always #5 clock = ~clock;

   for (genvar k = 1; k <= 4; k++) begin : g_lat
      rdma_ctyun_sdpram_ext_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();
      assign bus.wren      = wren;
      assign bus.byteena   = be;
      assign bus.wraddress = wa;
      assign bus.din       = din;
      assign bus.rden      = rden;
      assign bus.rdaddress = ra;
      rdma_ctyun_sdpram_ext #(
         .ADDR_WIDTH(4), .DATA_WIDTH(32), .READ_LATENCY(k),
         .RAM_TYPE("AUTO"), .FWD_EN(1'b1), .CLEAR_ON_RST(1'b1)
      ) dut (.clock(clock), .resetn(resetn), .bus(bus));
      assign dout_l[k]  = bus.dout;
      assign valid_l[k] = bus.dout_valid;
      assign init_l[k]  = bus.init_done;
   end

   rdma_ctyun_sdpram_ext_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus_f0 ();
   assign bus_f0.wren      = wren;
   assign bus_f0.byteena   = be;
   assign bus_f0.wraddress = wa;
   assign bus_f0.din       = din;
   assign bus_f0.rden      = rden;
   assign bus_f0.rdaddress = ra;
   rdma_ctyun_sdpram_ext #(
      .ADDR_WIDTH(4), .DATA_WIDTH(32), .READ_LATENCY(2),
      .RAM_TYPE("M20K"), .FWD_EN(1'b0), .CLEAR_ON_RST(1'b1)
   ) dut_f0 (.clock(clock), .resetn(resetn), .bus(bus_f0));

   rdma_ctyun_sdpram_ext_if #(.ADDR_WIDTH(4), .DATA_WIDTH(20)) bus_n20 ();
   assign bus_n20.wren      = wren;
   assign bus_n20.byteena   = be[2:0];
   assign bus_n20.wraddress = wa;
   assign bus_n20.din       = din[19:0];
   assign bus_n20.rden      = rden;
   assign bus_n20.rdaddress = ra;
   rdma_ctyun_sdpram_ext #(
      .ADDR_WIDTH(4), .DATA_WIDTH(20), .READ_LATENCY(2),
      .RAM_TYPE("MLAB"), .FWD_EN(1'b1), .CLEAR_ON_RST(1'b1)
   ) dut_n20 (.clock(clock), .resetn(resetn), .bus(bus_n20));

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
      wren = 1'b1; wa = a; din = d; be = m;
      step();
      wren = 1'b0;
   endtask

   // Walks 17 edges after reset release; init_done must rise on exactly the 17th.
   task automatic wait_init(input bit junk);
      for (int e = 1; e <= 17; e++) begin
         if (junk) begin
            wren = 1'b1; rden = 1'b1; wa = 4'(e); ra = 4'(e);
            din = 32'h5555_5555; be = 4'hf;
         end
         step();
         check_vec($sformatf("init_done e%0d", e), {28'b0, init_l}, (e == 17) ? 32'hf : 32'h0);
         check_vec($sformatf("init_done f0/n20 e%0d", e), {30'b0, bus_f0.init_done, bus_n20.init_done},
                   (e == 17) ? 32'h3 : 32'h0);
         if (junk) check_vec($sformatf("valid during clear e%0d", e), {27'b0, valid_l, bus_f0.dout_valid}, 32'h0);
      end
      wren = 1'b0; rden = 1'b0;
   endtask

   task automatic stream(input int n, input bit coll, input logic [3:0] c_be, input logic [31:0] c_din);
      int j;
      for (int i = 0; i < n + 4; i++) begin
         rden = (i < n);
         ra   = (i < n) ? rlist[i] : 4'h0;
         wren = coll && (i == 0);
         wa   = rlist[0];
         be   = c_be;
         din  = c_din;
         step();
         wren = 1'b0; rden = 1'b0;
         for (int l = 1; l <= 4; l++) begin
            j = i - l + 1;
            if (j >= 0 && j < n) begin
               check_vec($sformatf("L%0d valid r%0d", l, j), {31'b0, valid_l[l]}, 32'h1);
               check_vec($sformatf("L%0d dout r%0d", l, j), dout_l[l], e_fwd[j]);
            end else begin
               check_vec($sformatf("L%0d idle i%0d", l, i), {31'b0, valid_l[l]}, 32'h0);
               if (j >= n) check_vec($sformatf("L%0d hold i%0d", l, i), dout_l[l], e_fwd[n-1]);
            end
         end
         j = i - 1;
         if (j >= 0 && j < n) begin
            check_vec($sformatf("f0 valid r%0d", j), {31'b0, bus_f0.dout_valid}, 32'h1);
            check_vec($sformatf("f0 dout r%0d", j), bus_f0.dout, e_old[j]);
            check_vec($sformatf("n20 valid r%0d", j), {31'b0, bus_n20.dout_valid}, 32'h1);
            check_vec($sformatf("n20 dout r%0d", j), {12'b0, bus_n20.dout}, {12'b0, e_fwd[j][19:0]});
         end else begin
            check_vec($sformatf("f0/n20 idle i%0d", i), {30'b0, bus_f0.dout_valid, bus_n20.dout_valid}, 32'h0);
            if (j >= n) check_vec($sformatf("f0 hold i%0d", i), bus_f0.dout, e_old[n-1]);
         end
      end
   endtask

   task automatic set_zero_list();
      for (int a = 0; a < 16; a++) begin
         rlist[a] = 4'(a); e_fwd[a] = 32'h0; e_old[a] = 32'h0;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      resetn = 1'b0; wren = 1'b0; rden = 1'b0; be = 4'h0; wa = 4'h0; ra = 4'h0; din = 32'h0;
      @(negedge clock);
      step();
      step();
      check_vec("reset dout", dout_l[2], 32'h0);
      check_vec("reset valid", {28'b0, valid_l}, 32'h0);
      check_vec("reset init_done", {28'b0, init_l}, 32'h0);

      resetn = 1'b1;
      wait_init(1'b0);
      set_zero_list();
      stream(16, 1'b0, 4'h0, 32'h0);

      wr(4'd5, 32'hDEAD_BEEF, 4'hf);
      rlist[0] = 4'd5; e_fwd[0] = 32'hDEAD_BEEF; e_old[0] = 32'hDEAD_BEEF;
      stream(1, 1'b0, 4'h0, 32'h0);

      wr(4'd9, 32'h1122_3344, 4'hf);
      rlist[0] = 4'd9; e_fwd[0] = 32'h11BB_33DD; e_old[0] = 32'h1122_3344;
      rlist[1] = 4'd9; e_fwd[1] = 32'h11BB_33DD; e_old[1] = 32'h11BB_33DD;
      stream(2, 1'b1, 4'b0101, 32'hAABB_CCDD);

      wr(4'd2, 32'hFFFF_FFFF, 4'h0);
      rlist[0] = 4'd2; e_fwd[0] = 32'h0; e_old[0] = 32'h0;
      stream(1, 1'b0, 4'h0, 32'h0);

      for (int a = 0; a < 16; a++) begin
         wr(4'(a), 32'h1000_0000 + 32'(a) * 32'h0011_0101, 4'hf);
         rlist[a] = 4'(a);
         e_fwd[a] = 32'h1000_0000 + 32'(a) * 32'h0011_0101;
         e_old[a] = e_fwd[a];
      end
      stream(16, 1'b0, 4'h0, 32'h0);

      for (int a = 0; a < 16; a++) wr(4'(a), 32'h5555_5555, 4'hf);
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      for (int e = 1; e <= 7; e++) begin
         step();
         check_vec($sformatf("mid-clear init e%0d", e), {28'b0, init_l}, 32'h0);
      end
      resetn = 1'b0;
      step();
      check_vec("mid-clear reset dout", dout_l[1], 32'h0);
      resetn = 1'b1;
      wait_init(1'b1);
      set_zero_list();
      stream(16, 1'b0, 4'h0, 32'h0);

      wr(4'd3, 32'h1234_5678, 4'hf);
      wr(4'd3, 32'hFFFF_FFFF, 4'b0100);
      rlist[0] = 4'd3; e_fwd[0] = 32'h12FF_5678; e_old[0] = 32'h12FF_5678;
      stream(1, 1'b0, 4'h0, 32'h0);
      check_vec("n20 top lane", {12'b0, bus_n20.dout}, 32'h000F_5678);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
